apb_uart_regfile_fifo: RTL and testbench
========================================

Name: apb_uart_regfile_fifo

Overview:
Parametrised APB register block for the UART, replacing the single-entry TX/RX data registers with TX and RX FIFOs. Status flags are sticky write-1-to-clear, configuration registers honour byte strobes, and bad accesses raise PSLVERR. Sits between the APB slave interface and the UART TX/RX engines. TX uses a valid/ready handshake; RX uses a one-cycle valid pulse.

Parameters:
ADDR_W, 12, APB address width
TX_DEPTH, 8, TX FIFO entries (power of 2, >=2)
RX_DEPTH, 8, RX FIFO entries (power of 2, >=2)
LVL_W, $clog2(max(TX_DEPTH,RX_DEPTH))+1, level counter width (derived; not overridden)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
psel_i / penable_i / pwrite_i  in  1 each  APB control
paddr_i  in  ADDR_W  APB address
pwdata_i  in  32  write data
pstrb_i  in  4  byte strobes
prdata_o  out  32  read data
pready_o  out  1  always 1 (zero wait state)
pslverr_o  out  1  error response
tx_data_o  out  8  TX FIFO head byte
tx_valid_o  out  1  head byte valid
tx_ready_i  in  1  UART TX accepts byte
tx_done_i  in  1  pulse: frame transmitted
rx_data_i  in  8  received byte
rx_valid_i  in  1  pulse: rx_data_i valid
parity_error_i  in  1  pulse: parity error on current RX byte
data_bit_num_o  out  2  CFG[1:0]
stop_bit_num_o  out  1  CFG[2]
parity_en_o  out  1  CFG[3]
parity_type_o  out  1  CFG[4]
irq_o  out  1  interrupt (see Optional Feature)

Behaviour:
- Access = psel_i & penable_i. Write access = access & pwrite_i. Read access = access & !pwrite_i. pready_o is constant 1. pslverr_o and prdata_o are combinational and driven only during an access; otherwise both are 0.
- Register map:
  - 0x00 TXDATA (WO): a write with pstrb_i[0]=1 pushes pwdata_i[7:0]. If the TX FIFO is full, the byte is dropped and pslverr_o=1. A write with pstrb_i[0]=0 is ignored, no error. A read returns 0.
  - 0x04 RXDATA (RO): a read returns {24'b0, head} and pops the FIFO. If the FIFO is empty, the read returns 0 and pslverr_o=1. A write gives pslverr_o=1.
  - 0x08 CFG (RW): bits [4:0], written only when pstrb_i[0]=1. Other bits read 0.
  - 0x0C CTRL (RW): [0] tx_en, [1] rx_en, [2] tx_flush, [3] rx_flush. Flush bits are self-clearing and always read 0.
  - 0x10 STT: [0] tx_empty, [1] tx_full, [2] rx_empty, [3] rx_full (all RO). [4] parity_err, [5] rx_overrun, [6] tx_done (sticky, W1C via pwdata_i bits when pstrb_i[0]=1).
  - 0x14 IER (RW): bits [6:0].
  - 0x18 LEVEL (RO): [7:0] tx_level, [15:8] rx_level, zero-extended.
  - Any other address: read returns 0 with pslverr_o=1; a write is ignored with pslverr_o=1.
- Reset values: all registers, pointers and levels are 0; FIFOs are empty. Therefore STT reads 0x05, tx_valid_o=0, irq_o=0. tx_data_o=0 while empty. Config outputs are 0.
- TX path:
  - tx_valid_o = tx_en & !tx_empty. tx_data_o is the head byte.
  - A pop occurs when tx_valid_o & tx_ready_i.
  - Data written to an empty FIFO appears on tx_valid_o in the next cycle.
- RX path:
  - When rx_valid_i=1 and rx_en=1: the byte is pushed if the FIFO is not full. If full, the byte is dropped and rx_overrun is set.
  - When rx_en=0, rx_valid_i is ignored.
  - parity_error_i sets parity_err regardless of rx_en.
- Full/empty are computed from the registered level. A push into a full FIFO is rejected even if a pop occurs in the same cycle. A simultaneous push and pop on a non-full, non-empty FIFO leaves the level unchanged.
- Pointers wrap modulo DEPTH. Level ranges 0..DEPTH.
- Flush: a write of CTRL with bit2/bit3 set empties the TX/RX FIFO at that clock edge. Flush has priority over push and pop in the same cycle. The other CTRL bits are written normally in the same cycle.
- Sticky bits: a set event and a W1C in the same cycle leave the bit set.
- tx_done_i sets tx_done.
- Reset asserted mid-operation (e.g. in the middle of an APB access, or with the FIFOs partly full) returns everything to reset values at the next edge; the in-flight access is discarded.

Optional Feature:
UART_REG_IRQ_EN.
- Defined: irq_o = |(IER & {STT[6:4], !STT[2] (rx not empty), STT[0] (tx empty), 2'b00}), i.e. IER[6:4] gate the sticky bits, IER[3]=rx_not_empty, IER[2]=tx_empty, and IER[1:0] are reserved. irq_o is registered, 1 cycle after the cause.
- Not defined: irq_o is tied to 0, IER reads 0, and IER writes are ignored with no error.

Test Plan:
1. Reset, then read STT, LEVEL and CFG -> 0x05, 0x0, 0x0. pslverr_o=0 throughout.
2. CTRL=0x1 with tx_ready_i=0. Write TXDATA 0x11..0x18 (8 bytes), then a 9th write of 0x99 -> 9th access pslverr_o=1, LEVEL[7:0]=8, STT[1]=1. Then set tx_ready_i=1 -> bytes 0x11..0x18 appear in order, one per cycle, and tx_valid_o drops after 0x18.
3. CTRL=0x2. Pulse rx_valid_i nine times with 0xA0..0xA8 -> STT[5]=1 and 8 bytes are stored. Read RXDATA 8 times -> 0xA0..0xA7. A 9th read returns 0 with pslverr_o=1. Write STT=0x20 -> STT[5]=0.
4. Write CFG=0xFFFF_FF1F with pstrb_i=0x2 -> CFG unchanged (0). Rewrite with pstrb_i=0x1 -> reads 0x1F, and data_bit_num_o=3, stop=1, parity_en=1, parity_type=1.
5. Fill TX with 3 bytes (tx_en=0), then write CTRL=0x4 -> next cycle LEVEL[7:0]=0, STT[0]=1, CTRL reads 0.
6. With UART_REG_IRQ_EN: IER=0x10, pulse parity_error_i -> irq_o=1 one cycle later. Pulse parity_error_i again in the same cycle as a W1C write STT=0x10 -> bit stays set and irq_o stays 1. Clear with no concurrent event -> irq_o=0. Access to 0x40 -> pslverr_o=1.

Source files
------------

// File: rtl/apb_uart_regfile_fifo.sv
// APB register block for the UART with TX/RX FIFOs, sticky W1C status and PSLVERR.
// Optional interrupt logic is enabled by defining UART_REG_IRQ_EN.
module apb_uart_regfile_fifo #(
  parameter int ADDR_W   = 12,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [ADDR_W-1:0] paddr_i,
  input  logic [31:0]       pwdata_i,
  input  logic [3:0]        pstrb_i,
  output logic [31:0]       prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_valid_o,
  input  logic              tx_ready_i,
  input  logic              tx_done_i,
  input  logic [7:0]        rx_data_i,
  input  logic              rx_valid_i,
  input  logic              parity_error_i,
  output logic [1:0]        data_bit_num_o,
  output logic              stop_bit_num_o,
  output logic              parity_en_o,
  output logic              parity_type_o,
  output logic              irq_o
);

  localparam int MAX_DEPTH = (TX_DEPTH > RX_DEPTH) ? TX_DEPTH : RX_DEPTH;
  localparam int LVL_W     = $clog2(MAX_DEPTH) + 1;
  localparam int TX_PTR_W  = $clog2(TX_DEPTH);
  localparam int RX_PTR_W  = $clog2(RX_DEPTH);

  localparam logic [ADDR_W-1:0] ADDR_TXDATA = ADDR_W'('h00);
  localparam logic [ADDR_W-1:0] ADDR_RXDATA = ADDR_W'('h04);
  localparam logic [ADDR_W-1:0] ADDR_CFG    = ADDR_W'('h08);
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'('h0C);
  localparam logic [ADDR_W-1:0] ADDR_STT    = ADDR_W'('h10);
  localparam logic [ADDR_W-1:0] ADDR_IER    = ADDR_W'('h14);
  localparam logic [ADDR_W-1:0] ADDR_LEVEL  = ADDR_W'('h18);

  logic [7:0]          tx_mem [TX_DEPTH];
  logic [7:0]          rx_mem [RX_DEPTH];
  logic [TX_PTR_W-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [RX_PTR_W-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [LVL_W-1:0]    tx_level, rx_level;

  logic [4:0] cfg;
  logic       tx_en, rx_en;
  logic       parity_err, rx_overrun, tx_done_st;

  logic access, wr_access, rd_access;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_push, tx_pop, rx_push, rx_pop;
  logic tx_flush, rx_flush;
  logic ctrl_wr, cfg_wr, stt_w1c;
  logic overrun_set;
  logic [6:0] stt;
  logic [7:0] rx_head;
  logic unused_bits;

  assign access    = psel_i & penable_i;
  assign wr_access = access & pwrite_i;
  assign rd_access = access & ~pwrite_i;
  assign pready_o  = 1'b1;

  assign tx_empty = (tx_level == '0);
  assign tx_full  = (tx_level == LVL_W'(TX_DEPTH));
  assign rx_empty = (rx_level == '0);
  assign rx_full  = (rx_level == LVL_W'(RX_DEPTH));

  assign cfg_wr   = wr_access & (paddr_i == ADDR_CFG)  & pstrb_i[0];
  assign ctrl_wr  = wr_access & (paddr_i == ADDR_CTRL) & pstrb_i[0];
  assign stt_w1c  = wr_access & (paddr_i == ADDR_STT)  & pstrb_i[0];
  assign tx_flush = ctrl_wr & pwdata_i[2];
  assign rx_flush = ctrl_wr & pwdata_i[3];

  // Full is taken from the registered level, so a same-cycle pop never makes room.
  assign tx_push     = wr_access & (paddr_i == ADDR_TXDATA) & pstrb_i[0] & ~tx_full;
  assign tx_valid_o  = tx_en & ~tx_empty;
  assign tx_pop      = tx_valid_o & tx_ready_i;
  assign rx_push     = rx_valid_i & rx_en & ~rx_full;
  assign overrun_set = rx_valid_i & rx_en & rx_full;
  assign rx_pop      = rd_access & (paddr_i == ADDR_RXDATA) & ~rx_empty;

  assign rx_head   = rx_mem[rx_rd_ptr];
  assign tx_data_o = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr];

  assign stt = {tx_done_st, rx_overrun, parity_err, rx_full, rx_empty, tx_full, tx_empty};

  assign data_bit_num_o = cfg[1:0];
  assign stop_bit_num_o = cfg[2];
  assign parity_en_o    = cfg[3];
  assign parity_type_o  = cfg[4];

  assign unused_bits = ^{pwdata_i[31:8], pstrb_i[3:1]};

`ifdef UART_REG_IRQ_EN
  logic [6:0] ier;
  logic       irq;
  logic       ier_wr;

  assign ier_wr = wr_access & (paddr_i == ADDR_IER) & pstrb_i[0];
  assign irq_o  = irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      ier <= '0;
      irq <= 1'b0;
    end else begin
      if (ier_wr) ier <= pwdata_i[6:0];
      irq <= |(ier & {stt[6:4], ~stt[2], stt[0], 2'b00});
    end
  end
`else
  assign irq_o = 1'b0;
`endif

  // APB read mux and error response; both stay 0 outside an access
  always_comb begin
    prdata_o  = '0;
    pslverr_o = 1'b0;
    if (access) begin
      case (paddr_i)
        ADDR_TXDATA: pslverr_o = pwrite_i & pstrb_i[0] & tx_full;
        ADDR_RXDATA: begin
          if (pwrite_i || rx_empty) pslverr_o = 1'b1;
          else                      prdata_o  = {24'h0, rx_head};
        end
        ADDR_CFG:   prdata_o = {27'h0, cfg};
        ADDR_CTRL:  prdata_o = {30'h0, rx_en, tx_en};
        ADDR_STT:   prdata_o = {25'h0, stt};
`ifdef UART_REG_IRQ_EN
        ADDR_IER:   prdata_o = {25'h0, ier};
`else
        ADDR_IER:   prdata_o = '0;
`endif
        ADDR_LEVEL: prdata_o = {16'h0, 8'(rx_level), 8'(tx_level)};
        default:    pslverr_o = 1'b1;
      endcase
      if (pwrite_i) prdata_o = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push && !tx_flush) tx_mem[tx_wr_ptr] <= pwdata_i[7:0];
    if (rx_push && !rx_flush) rx_mem[rx_wr_ptr] <= rx_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg        <= '0;
      tx_en      <= 1'b0;
      rx_en      <= 1'b0;
      parity_err <= 1'b0;
      rx_overrun <= 1'b0;
      tx_done_st <= 1'b0;
      tx_wr_ptr  <= '0;
      tx_rd_ptr  <= '0;
      tx_level   <= '0;
      rx_wr_ptr  <= '0;
      rx_rd_ptr  <= '0;
      rx_level   <= '0;
    end else begin
      if (cfg_wr) cfg <= pwdata_i[4:0];
      if (ctrl_wr) begin
        tx_en <= pwdata_i[0];
        rx_en <= pwdata_i[1];
      end

      // A set event in the same cycle as a W1C wins
      parity_err <= (parity_err & ~(stt_w1c & pwdata_i[4])) | parity_error_i;
      rx_overrun <= (rx_overrun & ~(stt_w1c & pwdata_i[5])) | overrun_set;
      tx_done_st <= (tx_done_st & ~(stt_w1c & pwdata_i[6])) | tx_done_i;

      if (tx_flush) begin
        tx_wr_ptr <= '0;
        tx_rd_ptr <= '0;
        tx_level  <= '0;
      end else begin
        if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_PTR_W'(1);
        if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_PTR_W'(1);
        tx_level <= tx_level + LVL_W'(tx_push) - LVL_W'(tx_pop);
      end

      if (rx_flush) begin
        rx_wr_ptr <= '0;
        rx_rd_ptr <= '0;
        rx_level  <= '0;
      end else begin
        if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_PTR_W'(1);
        if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_PTR_W'(1);
        rx_level <= rx_level + LVL_W'(rx_push) - LVL_W'(rx_pop);
      end
    end
  end

endmodule

// File: tb/tb_apb_uart_regfile_fifo.sv
// Scoreboard bench for apb_uart_regfile_fifo: APB responses and TX bytes are
// queued at stimulus time and checked by a monitor when the DUT presents them.
module tb_apb_uart_regfile_fifo;
`ifdef UART_REG_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic        clk = 0, reset = 1;
  logic        psel = 0, penable = 0, pwrite = 0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready = 0, tx_done = 0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 0, parity_error = 0;
  logic [1:0]  data_bit_num;
  logic        stop_bit_num, parity_en, parity_type, irq;

  int checks = 0, failures = 0;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    logic        chk_rd;
    string       name;
  } apb_exp_t;
  apb_exp_t   apb_q[$];
  logic [7:0] tx_q[$];

  apb_uart_regfile_fifo #(.ADDR_W(12), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
    .clk(clk), .reset(reset),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
    .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .tx_done_i(tx_done), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .parity_error_i(parity_error),
    .data_bit_num_o(data_bit_num), .stop_bit_num_o(stop_bit_num),
    .parity_en_o(parity_en), .parity_type_o(parity_type), .irq_o(irq)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: compares APB responses and TX handshakes against the queues
  always @(negedge clk) begin
    if (!reset && psel && penable) begin
      if (apb_q.size() == 0) begin
        chk("apb_unexpected_access", 1, 0);
      end else begin
        apb_exp_t e;
        e = apb_q.pop_front();
        if (e.chk_rd) chk({e.name, "_rdata"}, prdata, e.rd);
        chk({e.name, "_pslverr"}, {31'h0, pslverr}, {31'h0, e.err});
        chk({e.name, "_pready"}, {31'h0, pready}, 32'h1);
      end
    end
    if (!reset && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) chk("tx_unexpected_byte", {24'h0, tx_data}, 32'hFFFF_FFFF);
      else                  chk("tx_byte", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
    end
  end

  task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [31:0] exp_rd,
                     input bit exp_err, input string name);
    apb_q.push_back('{exp_rd, exp_err, !wr, name});
    @(posedge clk); #1;
    psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    psel = 0; penable = 0; pwrite = 0; pstrb = '0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                    input bit err, input string name);
    apb(1, a, d, s, 32'h0, err, name);
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] exp, input bit err,
                    input string name);
    apb(0, a, 32'h0, 4'h0, exp, err, name);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(posedge clk); #1; rx_valid = 1; rx_data = b;
    @(posedge clk); #1; rx_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk("rst_tx_valid", {31'h0, tx_valid}, 0);
    chk("rst_tx_data", {24'h0, tx_data}, 0);
    chk("rst_irq", {31'h0, irq}, 0);
    chk("rst_cfg_out", {27'h0, parity_type, parity_en, stop_bit_num, data_bit_num}, 0);

    // Reset register values
    rd(12'h10, 32'h05, 0, "rst_stt");
    rd(12'h18, 32'h00, 0, "rst_level");
    rd(12'h08, 32'h00, 0, "rst_cfg");

    // TX fill to full, overflow, then drain in order
    wr(12'h0C, 32'h1, 4'hF, 0, "ctrl_txen");
    for (int i = 0; i < 8; i++) wr(12'h00, 32'h11 + i, 4'hF, 0, "tx_push");
    wr(12'h00, 32'h99, 4'hF, 1, "tx_overflow");
    rd(12'h18, 32'h08, 0, "tx_level_full");
    rd(12'h10, 32'h06, 0, "stt_tx_full");
    rd(12'h00, 32'h00, 0, "txdata_read");
    for (int i = 0; i < 8; i++) tx_q.push_back(8'h11 + 8'(i));
    @(posedge clk); #1 tx_ready = 1;
    repeat (12) @(posedge clk);
    #1;
    chk("tx_drained_all", tx_q.size(), 0);
    chk("tx_valid_after_drain", {31'h0, tx_valid}, 0);
    tx_ready = 0;
    @(posedge clk); #1 tx_done = 1;
    @(posedge clk); #1 tx_done = 0;
    rd(12'h10, 32'h45, 0, "stt_tx_done");
    wr(12'h10, 32'h40, 4'h1, 0, "w1c_tx_done");
    rd(12'h10, 32'h05, 0, "stt_tx_done_clr");

    // RX overrun and reads
    wr(12'h0C, 32'h2, 4'hF, 0, "ctrl_rxen");
    for (int i = 0; i < 9; i++) rx_pulse(8'hA0 + 8'(i));
    rd(12'h10, 32'h29, 0, "stt_rx_overrun");
    rd(12'h18, 32'h800, 0, "rx_level_full");
    for (int i = 0; i < 8; i++) rd(12'h04, 32'hA0 + i, 0, "rx_pop");
    rd(12'h04, 32'h0, 1, "rx_underflow");
    wr(12'h04, 32'h55, 4'hF, 1, "rxdata_write");
    wr(12'h10, 32'h20, 4'h1, 0, "w1c_overrun");
    rd(12'h10, 32'h05, 0, "stt_overrun_clr");

    // Byte strobes on CFG
    wr(12'h08, 32'hFFFF_FF1F, 4'h2, 0, "cfg_wr_nostrb");
    rd(12'h08, 32'h00, 0, "cfg_unchanged");
    wr(12'h08, 32'hFFFF_FF1F, 4'h1, 0, "cfg_wr_strb");
    rd(12'h08, 32'h1F, 0, "cfg_set");
    chk("cfg_outputs", {27'h0, parity_type, parity_en, stop_bit_num, data_bit_num}, 32'h1F);

    // Flush, and RX ignored while disabled
    wr(12'h0C, 32'h0, 4'hF, 0, "ctrl_off");
    for (int i = 0; i < 3; i++) wr(12'h00, 32'h30 + i, 4'hF, 0, "tx_push3");
    wr(12'h00, 32'h77, 4'h2, 0, "tx_push_nostrb");
    chk("tx_valid_when_disabled", {31'h0, tx_valid}, 0);
    rx_pulse(8'h5A);
    rd(12'h18, 32'h03, 0, "level_pre_flush");
    wr(12'h0C, 32'h4, 4'hF, 0, "tx_flush");
    rd(12'h18, 32'h00, 0, "level_post_flush");
    rd(12'h10, 32'h05, 0, "stt_post_flush");
    rd(12'h0C, 32'h00, 0, "ctrl_flush_selfclr");
    wr(12'h0C, 32'h2, 4'hF, 0, "ctrl_rxen2");
    rx_pulse(8'h66);
    rd(12'h18, 32'h100, 0, "rx_level_one");
    wr(12'h0C, 32'hA, 4'hF, 0, "rx_flush");
    rd(12'h18, 32'h000, 0, "rx_level_flushed");
    rd(12'h0C, 32'h02, 0, "ctrl_after_rxflush");

    // Interrupt and sticky set-beats-clear
    wr(12'h14, 32'h10, 4'hF, 0, "ier_wr");
    rd(12'h14, IRQ_ON ? 32'h10 : 32'h0, 0, "ier_rd");
    @(posedge clk); #1 parity_error = 1;
    @(posedge clk); #1 parity_error = 0;
    chk("irq_not_yet", {31'h0, irq}, 0);
    @(posedge clk); #1;
    chk("irq_parity", {31'h0, irq}, {31'h0, IRQ_ON});
    fork
      wr(12'h10, 32'h10, 4'h1, 0, "w1c_collide");
      begin
        repeat (2) @(posedge clk);
        #1 parity_error = 1;
        @(posedge clk); #1 parity_error = 0;
      end
    join
    @(posedge clk); #1;
    chk("irq_held", {31'h0, irq}, {31'h0, IRQ_ON});
    rd(12'h10, 32'h15, 0, "stt_parity_kept");
    wr(12'h10, 32'h10, 4'h1, 0, "w1c_parity");
    repeat (2) @(posedge clk);
    #1;
    chk("irq_cleared", {31'h0, irq}, 0);
    rd(12'h10, 32'h05, 0, "stt_parity_clr");
    rd(12'h40, 32'h0, 1, "bad_addr_rd");
    wr(12'h40, 32'h1, 4'hF, 1, "bad_addr_wr");

    // Reset with partly full FIFO and live config
    wr(12'h0C, 32'h1, 4'hF, 0, "ctrl_txen3");
    wr(12'h00, 32'hAB, 4'hF, 0, "tx_push_prerst");
    chk("tx_head_prerst", {23'h0, tx_valid, tx_data}, 32'h1AB);
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    chk("rst2_tx_valid", {31'h0, tx_valid}, 0);
    chk("rst2_cfg_out", {27'h0, parity_type, parity_en, stop_bit_num, data_bit_num}, 0);
    rd(12'h10, 32'h05, 0, "rst2_stt");
    rd(12'h18, 32'h00, 0, "rst2_level");
    rd(12'h08, 32'h00, 0, "rst2_cfg");
    rd(12'h0C, 32'h00, 0, "rst2_ctrl");

    repeat (3) @(posedge clk);
    #1;
    chk("apb_all_seen", apb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
